matvec_engine: RTL

- Parametrised matrix-vector multiply engine: computes C = A x B for a ROWS x COLS matrix A and a COLS-element vector B.
- Successor to the fixed 8x8, 8-bit matvec_mult. Adds:
  - generic dimensions and widths
  - runtime signed/unsigned mode
  - an element-addressed load port
  - a sticky overflow flag
  - a busy indication
- Sits between the host/load logic and downstream consumers of `results`.
- Uses ROWS parallel MAC lanes and consumes one column of A per cycle.

---
 rtl/matvec_pkg.sv | 15 +
 rtl/matvec_mac_lane.sv | 64 ++++++
 rtl/matvec_engine.sv | 121 ++++++++++++
 3 files changed

// File: rtl/matvec_pkg.sv
// Shared types and default dimensions for the matrix-vector engine.
package matvec_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_ROWS = 8;
   localparam int DEF_COLS = 8;
   localparam int DEF_DW   = 8;
   localparam int DEF_ACCW = 24;

endpackage

// File: rtl/matvec_mac_lane.sv
// One multiply-accumulate lane: acc += a*b each enabled cycle, with a sticky
// overflow flag that follows the selected signed/unsigned interpretation.
module matvec_mac_lane
   import matvec_pkg::*;
#(
   parameter int DW   = DEF_DW,
   parameter int ACCW = DEF_ACCW
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clr,
   input  logic            en,
   input  logic            signed_mode,
   input  logic [DW-1:0]   a,
   input  logic [DW-1:0]   b,
   output logic [ACCW-1:0] acc,
   output logic            ovf
);

   localparam int PW = 2 * DW;

   logic [PW-1:0]   a_x, b_x, prod;
   logic [ACCW-1:0] prod_x, acc_q, acc_d;
   logic [ACCW:0]   sum;
   logic            ovf_q, ovf_now;

   // NOTE: combinational logic uses blocking assignments so later lines see
   // the values computed above them within the same evaluation.
   always_comb begin
      if (signed_mode) begin
         a_x = PW'($signed(a));
         b_x = PW'($signed(b));
      end else begin
         a_x = PW'(a);
         b_x = PW'(b);
      end
      // The low PW bits of the extended-operand product are exact in both modes.
      prod = a_x * b_x;
      if (signed_mode) prod_x = ACCW'($signed(prod));
      else             prod_x = ACCW'(prod);
      sum   = {1'b0, acc_q} + {1'b0, prod_x};
      acc_d = sum[ACCW-1:0];
      if (signed_mode)
         ovf_now = (acc_q[ACCW-1] == prod_x[ACCW-1]) && (acc_d[ACCW-1] != acc_q[ACCW-1]);
      else
         ovf_now = sum[ACCW];
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         acc_q <= '0;
         ovf_q <= 1'b0;
      end else if (en) begin
         acc_q <= acc_d;
         if (ovf_now) ovf_q <= 1'b1;
      end
   end

   assign acc = acc_q;
   assign ovf = ovf_q;

endmodule

// File: rtl/matvec_engine.sv
// ROWS-lane matrix-vector engine: consumes one column of A per RUN cycle and
// leaves C = A x B on results while done is high.
module matvec_engine
   import matvec_pkg::*;
#(
   parameter int ROWS = DEF_ROWS,
   parameter int COLS = DEF_COLS,
   parameter int DW   = DEF_DW,
   parameter int ACCW = DEF_ACCW
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    Clr,
   input  logic                    a_wr_en,
   input  logic [$clog2(ROWS)-1:0] a_row,
   input  logic [$clog2(COLS)-1:0] a_col,
   input  logic [DW-1:0]           a_data,
   input  logic                    b_wr_en,
   input  logic [$clog2(COLS)-1:0] b_idx,
   input  logic [DW-1:0]           b_data,
   input  logic                    signed_mode,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   output logic                    ovf,
   output logic [ACCW-1:0]         results [0:ROWS-1]
);

   localparam int CW = $clog2(COLS);

   state_t          state_q;
   logic [CW-1:0]   col_cnt_q;
   logic            mode_q, busy_q, done_q;
   logic [DW-1:0]   a_mem_q [ROWS][COLS];
   logic [DW-1:0]   b_mem_q [COLS];

   logic            accept, lane_clr, lane_en;
   logic [DW-1:0]   b_sel;
   logic [ROWS-1:0] lane_ovf;

   // Clr outranks start; a start while RUN is simply not accepted.
   assign accept   = start && !Clr && (state_q != RUN);
   assign lane_clr = Clr || accept;
   assign lane_en  = (state_q == RUN);
   assign b_sel    = b_mem_q[col_cnt_q];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         col_cnt_q <= '0;
         mode_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else if (Clr) begin
         state_q   <= IDLE;
         col_cnt_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  state_q   <= RUN;
                  col_cnt_q <= '0;
                  mode_q    <= signed_mode;
                  busy_q    <= 1'b1;
                  done_q    <= 1'b0;
               end
            end
            RUN: begin
               if (col_cnt_q == CW'(COLS - 1)) begin
                  state_q   <= DONE;
                  col_cnt_q <= '0;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
               end else begin
                  col_cnt_q <= col_cnt_q + CW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // NOTE: operand storage is reset element by element so a job started right
   // after reset multiplies zeros; this rules out a RAM macro for A and B.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
               a_mem_q[r][c] <= '0;
         for (int c = 0; c < COLS; c++)
            b_mem_q[c] <= '0;
      end else if (state_q != RUN) begin
         if (a_wr_en) a_mem_q[a_row][a_col] <= a_data;
         if (b_wr_en) b_mem_q[b_idx] <= b_data;
      end
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_lane
      matvec_mac_lane #(
         .DW   (DW),
         .ACCW (ACCW)
      ) u_lane (
         .clk         (clk),
         .rst         (rst),
         .clr         (lane_clr),
         .en          (lane_en),
         .signed_mode (mode_q),
         .a           (a_mem_q[r][col_cnt_q]),
         .b           (b_sel),
         .acc         (results[r]),
         .ovf         (lane_ovf[r])
      );
   end

   assign busy = busy_q;
   assign done = done_q;
   assign ovf  = |lane_ovf;

endmodule
